// File: rtl/loop_nest_agu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : loop_nest_agu_if                                             |
// | Description : Command/response handshake bundle for loop_nest_agu.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface loop_nest_agu_if #(
    parameter int NUM_FORMULAS = 4,
    parameter int ADDR_W       = 18,
    parameter int CNT_W        = 8,
    parameter int PC_W         = 16
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [1:0]                     cmd_op;
    logic [CNT_W-1:0]               cmd_bound;
    logic [PC_W-1:0]                cmd_pc;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic                           rsp_jump;
    logic [PC_W-1:0]                rsp_target_pc;
    logic [NUM_FORMULAS*ADDR_W-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_bound, cmd_pc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_jump, rsp_target_pc, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bound, cmd_pc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_jump, rsp_target_pc, rsp_addr
    );
endinterface
`default_nettype wire

// File: rtl/loop_nest_agu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : loop_nest_agu                                                |
// | Description : Nested loop-counter stack with incremental affine address    |
// |               generation; optional stack bounds checking is enabled by     |
// |               defining LOOP_NEST_AGU_BOUNDS_CHECK_EN.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module loop_nest_agu #(
    parameter int  LOOP_DEPTH   = 8,
    parameter int  NUM_FORMULAS = 4,
    parameter int  ADDR_W       = 18,
    parameter int  CNT_W        = 8,
    parameter int  PC_W         = 16,
    localparam int C_DEPTH_W    = $clog2(LOOP_DEPTH + 1),
    localparam int C_FORM_W     = (NUM_FORMULAS > 1) ? $clog2(NUM_FORMULAS) : 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 cfg_we,
    input  wire logic [C_FORM_W-1:0]  cfg_formula,
    input  wire logic [C_DEPTH_W-1:0] cfg_level,
    input  wire logic [ADDR_W-1:0]    cfg_coef,
    loop_nest_agu_if.slave            bus,
    output logic [C_DEPTH_W-1:0]      depth,
    output logic                      overflow_err,
    output logic                      underflow_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] C_OP_START = 2'd0;
    localparam logic [1:0] C_OP_END   = 2'd1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_cmd_ready;
    logic                   w_rsp_valid;

    // Captured command
    logic [1:0]             r_op;
    logic [CNT_W-1:0]       r_bound;
    logic [PC_W-1:0]        r_pc;

    // Loop stack and formula state
    logic [CNT_W-1:0]       r_cnt   [LOOP_DEPTH];
    logic [CNT_W-1:0]       r_bnd   [LOOP_DEPTH];
    logic [PC_W-1:0]        r_lpc   [LOOP_DEPTH];
    logic [ADDR_W-1:0]      r_entry [LOOP_DEPTH][NUM_FORMULAS];
    logic [ADDR_W-1:0]      r_coef  [NUM_FORMULAS][LOOP_DEPTH];
    logic [ADDR_W-1:0]      r_addr  [NUM_FORMULAS];
    logic [C_DEPTH_W-1:0]   r_depth;

    logic                   r_rsp_jump;
    logic [PC_W-1:0]        r_rsp_pc;
    logic [ADDR_W-1:0]      r_rsp_addr [NUM_FORMULAS];
    logic [NUM_FORMULAS*ADDR_W-1:0] w_rsp_addr_flat;

    // Innermost-level view of the stack
    logic [CNT_W-1:0]       w_top_cnt;
    logic [CNT_W-1:0]       w_top_bnd;
    logic [PC_W-1:0]        w_top_pc;
    logic [PC_W-1:0]        w_below_pc;
    logic [ADDR_W-1:0]      w_top_entry [NUM_FORMULAS];
    logic [ADDR_W-1:0]      w_top_coef  [NUM_FORMULAS];

    logic                   w_can_push;
    logic                   w_can_pop;
    logic                   w_is_start;
    logic                   w_is_end;
    logic                   w_push;
    logic                   w_iterate;
    logic                   w_exit;
    logic                   w_cfg_fire;
    logic [CNT_W-1:0]       w_bnd_eff;
    logic [C_DEPTH_W-1:0]   w_depth_nxt;
    logic [PC_W-1:0]        w_pc_nxt;
    logic [ADDR_W-1:0]      w_addr_nxt [NUM_FORMULAS];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ stack top select
    always_comb begin
        w_top_cnt  = '0;
        w_top_bnd  = '0;
        w_top_pc   = '0;
        w_below_pc = '0;
        for (int f = 0; f < NUM_FORMULAS; f++) begin
            w_top_entry[f] = '0;
            w_top_coef[f]  = '0;
        end
        for (int i = 0; i < LOOP_DEPTH; i++) begin
            if (i == int'(r_depth) - 1) begin
                w_top_cnt = r_cnt[i];
                w_top_bnd = r_bnd[i];
                w_top_pc  = r_lpc[i];
                for (int f = 0; f < NUM_FORMULAS; f++) begin
                    w_top_entry[f] = r_entry[i][f];
                    w_top_coef[f]  = r_coef[f][i];
                end
            end
            if (i == int'(r_depth) - 2) w_below_pc = r_lpc[i];
        end
    end

`ifdef LOOP_NEST_AGU_BOUNDS_CHECK_EN
    assign w_can_push = (int'(r_depth) < LOOP_DEPTH);
    assign w_can_pop  = (r_depth != '0);
`else
    assign w_can_push = 1'b1;
    assign w_can_pop  = 1'b1;
`endif

    // ------------------------------------------------------- command decode
    assign w_cfg_fire = cfg_we && (r_state == S_IDLE);
    assign w_is_start = (r_state == S_EXEC) && (r_op == C_OP_START);
    assign w_is_end   = (r_state == S_EXEC) && (r_op == C_OP_END);
    assign w_push     = w_is_start && w_can_push;
    assign w_iterate  = w_is_end && w_can_pop && (w_top_cnt < (w_top_bnd - CNT_W'(1)));
    assign w_exit     = w_is_end && w_can_pop && !w_iterate;
    assign w_bnd_eff  = (r_bound == '0) ? CNT_W'(1) : r_bound;

    always_comb begin
        w_depth_nxt = r_depth;
        if (w_push)      w_depth_nxt = r_depth + C_DEPTH_W'(1);
        else if (w_exit) w_depth_nxt = r_depth - C_DEPTH_W'(1);

        // Target PC reflects the stack as it will stand after this command
        if (w_push)               w_pc_nxt = r_pc;
        else if (w_exit)          w_pc_nxt = w_below_pc;
        else if (r_depth == '0)   w_pc_nxt = '0;
        else                      w_pc_nxt = w_top_pc;

        for (int f = 0; f < NUM_FORMULAS; f++) begin
            w_addr_nxt[f] = r_addr[f];
            if (w_iterate)   w_addr_nxt[f] = r_addr[f] + w_top_coef[f];
            else if (w_exit) w_addr_nxt[f] = w_top_entry[f];
        end
    end

    // -------------------------------------------------------------- datapath
    // A base value only ever surfaces through addr (reset clears both), so it
    // is folded directly into the running address instead of being stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= '0;
            r_bound    <= '0;
            r_pc       <= '0;
            r_depth    <= '0;
            r_rsp_jump <= 1'b0;
            r_rsp_pc   <= '0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                r_cnt[i] <= '0;
                r_bnd[i] <= '0;
                r_lpc[i] <= '0;
                for (int f = 0; f < NUM_FORMULAS; f++) r_entry[i][f] <= '0;
            end
            for (int f = 0; f < NUM_FORMULAS; f++) begin
                r_addr[f]     <= '0;
                r_rsp_addr[f] <= '0;
                for (int i = 0; i < LOOP_DEPTH; i++) r_coef[f][i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && bus.cmd_valid) begin
                r_op    <= bus.cmd_op;
                r_bound <= bus.cmd_bound;
                r_pc    <= bus.cmd_pc;
            end

            if (w_cfg_fire) begin
                for (int f = 0; f < NUM_FORMULAS; f++) begin
                    if (f == int'(cfg_formula)) begin
                        if (int'(cfg_level) == LOOP_DEPTH && r_depth == '0) r_addr[f] <= cfg_coef;
                        for (int i = 0; i < LOOP_DEPTH; i++) begin
                            if (i == int'(cfg_level)) r_coef[f][i] <= cfg_coef;
                        end
                    end
                end
            end

            if (r_state == S_EXEC) begin
                r_depth    <= w_depth_nxt;
                r_rsp_jump <= w_iterate;
                r_rsp_pc   <= w_pc_nxt;
                for (int i = 0; i < LOOP_DEPTH; i++) begin
                    if (w_push && i == int'(r_depth)) begin
                        r_cnt[i] <= '0;
                        r_bnd[i] <= w_bnd_eff;
                        r_lpc[i] <= r_pc;
                        for (int f = 0; f < NUM_FORMULAS; f++) r_entry[i][f] <= r_addr[f];
                    end
                    if (w_iterate && i == int'(r_depth) - 1) r_cnt[i] <= w_top_cnt + CNT_W'(1);
                end
                for (int f = 0; f < NUM_FORMULAS; f++) begin
                    r_addr[f]     <= w_addr_nxt[f];
                    r_rsp_addr[f] <= w_addr_nxt[f];
                end
            end
        end
    end

`ifdef LOOP_NEST_AGU_BOUNDS_CHECK_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_is_start && !w_can_push) r_ovf <= 1'b1;
            if (w_is_end && !w_can_pop)    r_udf <= 1'b1;
        end
    end

    assign overflow_err  = r_ovf;
    assign underflow_err = r_udf;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    // ----------------------------------------------------------------- outputs
    always_comb begin
        w_rsp_addr_flat = '0;
        for (int f = 0; f < NUM_FORMULAS; f++) begin
            w_rsp_addr_flat[f*ADDR_W +: ADDR_W] = r_rsp_addr[f];
        end
    end

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_jump      = r_rsp_jump;
    assign bus.rsp_target_pc = r_rsp_pc;
    assign bus.rsp_addr      = w_rsp_addr_flat;
    assign depth             = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_loop_nest_agu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_loop_nest_agu                                             |
// | Description : Directed and random checks of loop_nest_agu against a       |
// |               frame-stack reference model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_loop_nest_agu;

    localparam int LD = 8;
    localparam int NF = 4;
    localparam int AW = 18;
    localparam int CW = 8;
    localparam int PW = 16;
    localparam int DW = 4;
    localparam int FW = 2;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_END   = 2'd1;
    localparam logic [1:0] OP_QUERY = 2'd2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [FW-1:0] cfg_formula = '0;
    logic [DW-1:0] cfg_level = '0;
    logic [AW-1:0] cfg_coef = '0;
    logic [DW-1:0] depth;
    logic          overflow_err;
    logic          underflow_err;

    loop_nest_agu_if #(.NUM_FORMULAS(NF), .ADDR_W(AW), .CNT_W(CW), .PC_W(PW)) bus ();

    loop_nest_agu #(
        .LOOP_DEPTH(LD), .NUM_FORMULAS(NF), .ADDR_W(AW), .CNT_W(CW), .PC_W(PW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_we       (cfg_we),
        .cfg_formula  (cfg_formula),
        .cfg_level    (cfg_level),
        .cfg_coef     (cfg_coef),
        .bus          (bus),
        .depth        (depth),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------- reference model
    typedef struct {
        int unsigned     cnt;
        int unsigned     bnd;
        logic [PW-1:0]   pc;
        logic [NF*AW-1:0] entry;
    } frame_t;

    frame_t      m_stack[$];
    logic [AW-1:0] m_coef [NF][LD];
    logic [AW-1:0] m_addr [NF];
    bit          m_ovf;
    bit          m_udf;

    int n_vec;
    int n_err;

    function automatic logic [NF*AW-1:0] pack_addr();
        logic [NF*AW-1:0] v;
        for (int f = 0; f < NF; f++) v[f*AW +: AW] = m_addr[f];
        return v;
    endfunction

    function automatic void model_reset();
        m_stack.delete();
        for (int f = 0; f < NF; f++) begin
            m_addr[f] = '0;
            for (int k = 0; k < LD; k++) m_coef[f][k] = '0;
        end
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    function automatic bit model_cmd(input logic [1:0] op, input int unsigned bound,
                                     input logic [PW-1:0] pc);
        frame_t fr;
        int     k;
        bit     jump = 1'b0;
        if (op == OP_START) begin
            if (m_stack.size() < LD) begin
                fr.cnt   = 0;
                fr.bnd   = (bound == 0) ? 1 : bound;
                fr.pc    = pc;
                fr.entry = pack_addr();
                m_stack.push_back(fr);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (op == OP_END) begin
            if (m_stack.size() > 0) begin
                k  = m_stack.size() - 1;
                fr = m_stack[k];
                if (fr.cnt + 1 < fr.bnd) begin
                    fr.cnt++;
                    m_stack[k] = fr;
                    for (int f = 0; f < NF; f++) m_addr[f] = m_addr[f] + m_coef[f][k];
                    jump = 1'b1;
                end else begin
                    for (int f = 0; f < NF; f++) m_addr[f] = fr.entry[f*AW +: AW];
                    void'(m_stack.pop_back());
                end
            end else begin
                m_udf = 1'b1;
            end
        end
        return jump;
    endfunction

    function automatic logic [PW-1:0] model_pc();
        if (m_stack.size() == 0) return '0;
        return m_stack[m_stack.size()-1].pc;
    endfunction

    function automatic bit exp_ovf();
`ifdef LOOP_NEST_AGU_BOUNDS_CHECK_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_udf();
`ifdef LOOP_NEST_AGU_BOUNDS_CHECK_EN
        return m_udf;
`else
        return 1'b0;
`endif
    endfunction

    // ------------------------------------------------------------------ checks
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input bit jump, input logic [PW-1:0] pc);
        chk({tag, "_valid"}, 128'(bus.rsp_valid), 128'(1'b1));
        chk({tag, "_jump"},  128'(bus.rsp_jump), 128'(jump));
        chk({tag, "_pc"},    128'(bus.rsp_target_pc), 128'(pc));
        chk({tag, "_addr"},  128'(bus.rsp_addr), 128'(pack_addr()));
        chk({tag, "_depth"}, 128'(depth), 128'(m_stack.size()));
        chk({tag, "_ovf"},   128'(overflow_err), 128'(exp_ovf()));
        chk({tag, "_udf"},   128'(underflow_err), 128'(exp_udf()));
    endtask

    task automatic do_cfg(input int f, input int lvl, input logic [AW-1:0] val);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_formula = FW'(f);
        cfg_level   = DW'(lvl);
        cfg_coef    = val;
        @(negedge clk);
        cfg_we = 1'b0;
        if (lvl == LD) begin
            if (m_stack.size() == 0) m_addr[f] = val;
        end else begin
            m_coef[f][lvl] = val;
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input int unsigned bound,
                          input int unsigned pc, input int hold, input bit poke);
        int            waited = 0;
        bit            jump;
        logic [PW-1:0] epc;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_bound = CW'(bound);
        bus.cmd_pc    = PW'(pc);
        bus.rsp_ready = (hold == 0);
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            chk("handshake_timeout", 128'(1'b0), 128'(1'b1));
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("exec_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
        chk("exec_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
        jump = model_cmd(op, bound, PW'(pc));
        epc  = model_pc();
        @(negedge clk);
        chk_rsp("rsp", jump, epc);
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 0) begin
                cfg_we      = 1'b1;
                cfg_formula = FW'(2);
                cfg_level   = DW'(0);
                cfg_coef    = AW'(5);
            end
            @(negedge clk);
            cfg_we = 1'b0;
            chk("hold_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
            chk("hold_jump", 128'(bus.rsp_jump), 128'(jump));
            chk("hold_pc",   128'(bus.rsp_target_pc), 128'(epc));
            chk("hold_addr", 128'(bus.rsp_addr), 128'(pack_addr()));
            chk("hold_valid", 128'(bus.rsp_valid), 128'(1'b1));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
        chk("done_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- sequence
    initial begin
        int unsigned r;
        logic [1:0]  op;
        int          guard;
        n_vec = 0;
        n_err = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_bound = '0;
        bus.cmd_pc    = '0;
        bus.rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("reset_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));
        chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
        chk("reset_jump",      128'(bus.rsp_jump), 128'(1'b0));
        chk("reset_pc",        128'(bus.rsp_target_pc), 128'(0));
        chk("reset_addr",      128'(bus.rsp_addr), 128'(0));
        chk("reset_depth",     128'(depth), 128'(0));
        chk("reset_ovf",       128'(overflow_err), 128'(1'b0));
        chk("reset_udf",       128'(underflow_err), 128'(1'b0));

        do_cmd(OP_QUERY, 0, 0, 0, 1'b0);

        // Single loop: coef[0][0]=2, base[1]=3
        do_cfg(0, 0, AW'(2));
        do_cfg(1, LD, AW'(3));
        do_cmd(OP_START, 3, 7, 0, 1'b0);
        repeat (3) do_cmd(OP_END, 0, 0, 0, 1'b0);

        // Nested loops
        do_cfg(0, 0, AW'(16));
        do_cfg(0, 1, AW'(1));
        do_cmd(OP_START, 2, 10, 0, 1'b0);
        do_cmd(OP_START, 2, 20, 0, 1'b0);
        repeat (3) do_cmd(OP_END, 0, 0, 0, 1'b0);
        do_cmd(OP_START, 2, 20, 0, 1'b0);
        repeat (3) do_cmd(OP_END, 0, 0, 0, 1'b0);

        // Response back-pressure with a dropped cfg write
        do_cmd(OP_QUERY, 0, 0, 5, 1'b1);
        do_cmd(OP_START, 2, 33, 3, 1'b0);
        do_cmd(OP_END, 0, 0, 2, 1'b0);
        do_cmd(OP_END, 0, 0, 0, 1'b0);

        // Address wrap
        do_cfg(0, 0, {AW{1'b1}});
        do_cmd(OP_START, 3, 44, 0, 1'b0);
        repeat (3) do_cmd(OP_END, 0, 0, 0, 1'b0);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_cfg(int'($urandom_range(0, NF-1)), int'($urandom_range(0, LD)), AW'($urandom));
            end else begin
                op = 2'($urandom_range(0, 3));
`ifndef LOOP_NEST_AGU_BOUNDS_CHECK_EN
                if (m_stack.size() == 0 && op == OP_END) op = OP_START;
                if (m_stack.size() == LD && op == OP_START) op = OP_END;
`endif
                do_cmd(op, $urandom_range(0, 4), $urandom_range(0, 65535),
                       int'($urandom_range(0, 2)), 1'b0);
            end
        end
        guard = 0;
        while (m_stack.size() > 0 && guard < 100) begin
            do_cmd(OP_END, 0, 0, 0, 1'b0);
            guard++;
        end

`ifdef LOOP_NEST_AGU_BOUNDS_CHECK_EN
        for (int i = 0; i < LD + 1; i++) do_cmd(OP_START, 1, 100 + i, 0, 1'b0);
        chk("ovf_flag",  128'(overflow_err), 128'(1'b1));
        chk("ovf_depth", 128'(depth), 128'(LD));
        for (int i = 0; i < LD; i++) do_cmd(OP_END, 0, 0, 0, 1'b0);
        do_cmd(OP_END, 0, 0, 0, 1'b0);
        chk("udf_flag",  128'(underflow_err), 128'(1'b1));
        chk("udf_depth", 128'(depth), 128'(0));
`endif

        // Asynchronous reset while a response is pending
        do_cmd(OP_START, 2, 55, 0, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_QUERY;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_rsp_valid", 128'(bus.rsp_valid), 128'(1'b1));
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
        chk("async_rst_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));
        chk("async_rst_depth",     128'(depth), 128'(0));
        chk("async_rst_addr",      128'(bus.rsp_addr), 128'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        bus.rsp_ready = 1'b1;
        do_cmd(OP_QUERY, 0, 0, 0, 1'b0);
        do_cmd(OP_START, 2, 66, 0, 1'b0);
        do_cmd(OP_END, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
